// File: rtl/modn_pkg.sv
// rtl/modn_pkg.sv - shared types and JK encode helper for the mod-N JK counter
package modn_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Smallest J/K pair that moves a flip-flop from cur_bit to nxt_bit:
    // set when rising, clear when falling, hold when unchanged.
    function automatic logic [1:0] jk_for(input logic cur_bit, input logic nxt_bit);
        logic [1:0] jk;
        case ({cur_bit, nxt_bit})
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// rtl/jk_stage.sv - single JK flip-flop with async active-low preset and clear
//
// Ports:
//   clk    posedge clock
//   pre_n  async preset, active-low (forces q=1)
//   clr_n  async clear, active-low (forces q=0, wins over preset)
//   j, k   synchronous JK controls (00 hold, 10 set, 01 clear, 11 toggle)
//   q      state
//   qbar   complement of state
module jk_stage (
    input  logic clk,
    input  logic pre_n,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge clr_n or negedge pre_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else if (!pre_n) begin
            q <= 1'b1;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/modn_jk_counter.sv
// rtl/modn_jk_counter.sv - mod-N up/down counter built from JK stages
//
// Ports:
//   clk       posedge clock
//   clr       async reset, active-low; clears count, wrap, load_err
//   en        count enable
//   up_dn     1 = up, 0 = down
//   load      synchronous parallel load (beats en)
//   load_val  value to load; values >= MODULUS load 0 and flag load_err
//   count     current count, 0..MODULUS-1
//   tc        combinational cascade carry for the next digit's en
//   wrap      one-cycle pulse in the cycle after a MODULUS-1 <-> 0 crossing
//   load_err  one-cycle pulse in the cycle after an out-of-range load
module modn_jk_counter
    import modn_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_max;
    logic             at_zero;
    logic             in_range;
    logic             wrap_d;
    logic             load_err_d;
    dir_e             dir;

    assign count    = q;
    assign dir      = dir_e'(up_dn);
    assign at_max   = (q == MAX_CNT);
    // All complement outputs high means every stage is clear.
    assign at_zero  = &qbar;
    assign in_range = ({1'b0, q} < MOD_EXT);

    always_comb begin
        next_count = q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                next_count = load_val;
            end else begin
                next_count = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (!in_range) begin
                // Recovery from a state that normal operation never reaches.
                next_count = '0;
            end else if (dir == DIR_UP) begin
                if (at_max) begin
                    next_count = '0;
                    wrap_d     = 1'b1;
                end else begin
                    next_count = q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    next_count = MAX_CNT;
                    wrap_d     = 1'b1;
                end else begin
                    next_count = q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_for(q[i], next_count[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            jk_stage u_stage (
                .clk   (clk),
                .pre_n (1'b1),
                .clr_n (clr),
                .j     (j[gi]),
                .k     (k[gi]),
                .q     (q[gi]),
                .qbar  (qbar[gi])
            );
        end
    endgenerate

    assign tc = en & ~load & ((dir == DIR_UP) ? at_max : at_zero);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_d;
            load_err <= load_err_d;
        end
    end

endmodule
